// File: rtl/sram_master_pkg.sv
// =============================================================================
// sram_master_pkg : FSM state type for sram_master
// RB_* states exist only with SRAM_MASTER_READBACK_EN defined.
// Rev 1.0 - initial release
// =============================================================================
`default_nettype none

`ifndef SRAM_MASTER_DEFS_SV
`include "sram_master_defs.sv"
`endif

package sram_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = `SM_ST_IDLE,
    ST_SETUP     = `SM_ST_SETUP,
    ST_ACCESS    = `SM_ST_ACCESS,
    ST_HOLD      = `SM_ST_HOLD,
    ST_ACK       = `SM_ST_ACK
`ifdef SRAM_MASTER_READBACK_EN
    ,
    ST_RB_SETUP  = `SM_ST_RB_SETUP,
    ST_RB_ACCESS = `SM_ST_RB_ACCESS,
    ST_RB_HOLD   = `SM_ST_RB_HOLD
`endif
  } sm_state_e;

endpackage

`default_nettype wire

// File: rtl/sram_master_defs.sv
// =============================================================================
// sram_master_defs : shared state encodings and default access length
// Rev 1.0 - initial release
// =============================================================================
`default_nettype none

`ifndef SRAM_MASTER_DEFS_SV
`define SRAM_MASTER_DEFS_SV

`define SM_ST_IDLE      3'd0
`define SM_ST_SETUP     3'd1
`define SM_ST_ACCESS    3'd2
`define SM_ST_HOLD      3'd3
`define SM_ST_ACK       3'd4
`define SM_ST_RB_SETUP  3'd5
`define SM_ST_RB_ACCESS 3'd6
`define SM_ST_RB_HOLD   3'd7

`define SM_DEFAULT_WAIT_CYCLES 2

`endif

`default_nettype wire

// File: rtl/sram_master_wait_counter.sv
// =============================================================================
// wait_counter : loadable down-counter, tc_o high while the count equals 1
// Rev 1.0 - initial release
// =============================================================================
`default_nettype none

module wait_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/sram_master.sv
// =============================================================================
// sram_master : four-phase client request to sequenced async SRAM cycle
// SRAM_MASTER_READBACK_EN adds a verify read after every write (err port).
// Rev 1.0 - initial release
// =============================================================================
`default_nettype none

module sram_master
  import sram_master_pkg::*;
#(
  parameter int N           = 4,
  parameter int M           = 4,
  parameter int WAIT_CYCLES = `SM_DEFAULT_WAIT_CYCLES
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req,
  input  logic         we,
  input  logic [N-1:0] addr_in,
  input  logic [M-1:0] wdata,
  output logic [M-1:0] rdata,
  output logic         ack,
  output logic         busy,
`ifdef SRAM_MASTER_READBACK_EN
  output logic         err,
`endif
  output logic         s_,
  output logic         mr_,
  output logic         mw_,
  output logic [N-1:0] addr,
  output logic [M-1:0] data_out,
  output logic         data_oe,
  input  logic [M-1:0] data_in
);

  localparam int C_CNT_W = $clog2(WAIT_CYCLES + 1);

  sm_state_e    state_q, state_d;
  logic         we_q, we_d;
  logic         s_q, s_d;
  logic         mr_q, mr_d;
  logic         mw_q, mw_d;
  logic [N-1:0] addr_q, addr_d;
  logic [M-1:0] data_out_q, data_out_d;
  logic         data_oe_q, data_oe_d;
  logic [M-1:0] rdata_q, rdata_d;
  logic         ack_q, ack_d;
  logic         busy_q, busy_d;
`ifdef SRAM_MASTER_READBACK_EN
  logic [M-1:0] wdata_q, wdata_d;
  logic         err_q, err_d;
`endif

  logic         cnt_load;
  logic         cnt_dec;
  logic         cnt_tc;

  wait_counter #(
    .WIDTH (C_CNT_W)
  ) u_wait_counter (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (C_CNT_W'(WAIT_CYCLES)),
    .tc_o       (cnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    s_d        = s_q;
    mr_d       = mr_q;
    mw_d       = mw_q;
    addr_d     = addr_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    rdata_d    = rdata_q;
    ack_d      = ack_q;
    busy_d     = busy_q;
`ifdef SRAM_MASTER_READBACK_EN
    wdata_d    = wdata_q;
    err_d      = err_q;
`endif
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d    = ST_SETUP;
          we_d       = we;
          addr_d     = addr_in;
          busy_d     = 1'b1;
          s_d        = 1'b0;
          data_oe_d  = we;
          data_out_d = we ? wdata : data_out_q;
`ifdef SRAM_MASTER_READBACK_EN
          wdata_d    = wdata;
          err_d      = 1'b0;
`endif
        end
      end
      ST_SETUP: begin
        state_d  = ST_ACCESS;
        cnt_load = 1'b1;
        mr_d     = we_q;
        mw_d     = ~we_q;
      end
      ST_ACCESS: begin
        if (cnt_tc) begin
          state_d = ST_HOLD;
          mr_d    = 1'b1;
          mw_d    = 1'b1;
          if (!we_q) begin
            rdata_d = data_in;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HOLD: begin
`ifdef SRAM_MASTER_READBACK_EN
        if (we_q) begin
          // verify read of the same location; bus released to the SRAM
          state_d   = ST_RB_SETUP;
          data_oe_d = 1'b0;
        end else begin
          state_d   = ST_ACK;
          s_d       = 1'b1;
          data_oe_d = 1'b0;
          ack_d     = 1'b1;
        end
`else
        state_d   = ST_ACK;
        s_d       = 1'b1;
        data_oe_d = 1'b0;
        ack_d     = 1'b1;
`endif
      end
`ifdef SRAM_MASTER_READBACK_EN
      ST_RB_SETUP: begin
        state_d  = ST_RB_ACCESS;
        cnt_load = 1'b1;
        mr_d     = 1'b0;
      end
      ST_RB_ACCESS: begin
        if (cnt_tc) begin
          state_d = ST_RB_HOLD;
          mr_d    = 1'b1;
          err_d   = (data_in != wdata_q);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RB_HOLD: begin
        state_d = ST_ACK;
        s_d     = 1'b1;
        ack_d   = 1'b1;
      end
`endif
      ST_ACK: begin
        if (!req) begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      s_q        <= 1'b1;
      mr_q       <= 1'b1;
      mw_q       <= 1'b1;
      addr_q     <= '0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SRAM_MASTER_READBACK_EN
      wdata_q    <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      s_q        <= s_d;
      mr_q       <= mr_d;
      mw_q       <= mw_d;
      addr_q     <= addr_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
`ifdef SRAM_MASTER_READBACK_EN
      wdata_q    <= wdata_d;
      err_q      <= err_d;
`endif
    end
  end

  assign s_       = s_q;
  assign mr_      = mr_q;
  assign mw_      = mw_q;
  assign addr     = addr_q;
  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;
  assign rdata    = rdata_q;
  assign ack      = ack_q;
  assign busy     = busy_q;
`ifdef SRAM_MASTER_READBACK_EN
  assign err      = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_master.sv
// =============================================================================
// tb_sram_master : randomized self-checking bench for sram_master with an
// SRAM bank model and a reference memory; honours SRAM_MASTER_READBACK_EN.
// Rev 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_sram_master;

  localparam int N = 4;
  localparam int M = 4;
  localparam int W = 2;
`ifdef SRAM_MASTER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int RD_LAT = 2 + W;
  localparam int WR_LAT = RB ? (4 + 2 * W) : (2 + W);
  localparam int WR_MR  = RB ? W : 0;

  logic         clock = 1'b0;
  logic         reset;
  logic         req;
  logic         we;
  logic [N-1:0] addr_in;
  logic [M-1:0] wdata;
  logic [M-1:0] rdata;
  logic         ack;
  logic         busy;
  logic         s_;
  logic         mr_;
  logic         mw_;
  logic [N-1:0] addr;
  logic [M-1:0] data_out;
  logic         data_oe;
  logic [M-1:0] data_in;
`ifdef SRAM_MASTER_READBACK_EN
  logic         err;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [M-1:0] mem     [2**N];
  logic [M-1:0] ref_mem [2**N];
  bit           stuck0 = 1'b0;

  sram_master #(
    .N           (N),
    .M           (M),
    .WAIT_CYCLES (W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .we       (we),
    .addr_in  (addr_in),
    .wdata    (wdata),
    .rdata    (rdata),
    .ack      (ack),
    .busy     (busy),
`ifdef SRAM_MASTER_READBACK_EN
    .err      (err),
`endif
    .s_       (s_),
    .mr_      (mr_),
    .mw_      (mw_),
    .addr     (addr),
    .data_out (data_out),
    .data_oe  (data_oe),
    .data_in  (data_in)
  );

  always #5 clock = ~clock;

  // SRAM bank: latches on the rising write strobe, optional stuck-at-0 bit 0
  always @(posedge mw_) begin
    if (s_ === 1'b0 && data_oe === 1'b1)
      mem[addr] <= stuck0 ? (data_out & ~M'(1)) : data_out;
  end
  assign data_in = (s_ === 1'b0 && mr_ === 1'b0) ? mem[addr] : '0;

  // One complete transaction; inputs are scrambled after acceptance.
  task automatic run_txn(input bit w, input logic [N-1:0] a, input logic [M-1:0] d,
                         input int hold, output int lat, output int s_lo,
                         output int mr_lo, output int mw_lo, output int oe_lo,
                         output int both_lo, output logic [M-1:0] rd,
                         output logic er, output bit stayed, output bit released);
    int k;
    lat = -1; s_lo = 0; mr_lo = 0; mw_lo = 0; oe_lo = 0; both_lo = 0;
    rd = '0; er = 1'b0; stayed = 1'b1; released = 1'b0;
    @(negedge clock);
    req = 1'b1; we = w; addr_in = a; wdata = d;
    @(posedge clock); #1;
    we = 1'($urandom); addr_in = N'($urandom); wdata = M'($urandom);
    k = 0;
    while (ack !== 1'b1 && k < 60) begin
      if (s_ === 1'b0) s_lo++;
      if (mr_ === 1'b0) mr_lo++;
      if (mw_ === 1'b0) mw_lo++;
      if (data_oe === 1'b1) oe_lo++;
      if (mr_ === 1'b0 && mw_ === 1'b0) both_lo++;
      @(posedge clock); #1;
      k++;
    end
    if (ack === 1'b1) lat = k;
    rd = rdata;
`ifdef SRAM_MASTER_READBACK_EN
    er = err;
`endif
    repeat (hold) begin
      @(posedge clock); #1;
      if (!(ack === 1'b1 && busy === 1'b1 && s_ === 1'b1 && mr_ === 1'b1 && mw_ === 1'b1))
        stayed = 1'b0;
    end
    @(negedge clock);
    req = 1'b0;
    @(posedge clock); #1;
    released = (ack === 1'b0 && busy === 1'b0);
  endtask

  task automatic test_reset();
    @(negedge clock);
    req = 1'b1; we = 1'b1; addr_in = N'(9); wdata = M'(6);
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    vectors++; if (s_ !== 1'b1) begin miscompares++; $display("FAIL rst_s_: got %b want 1", s_); end
    vectors++; if (mr_ !== 1'b1) begin miscompares++; $display("FAIL rst_mr_: got %b want 1", mr_); end
    vectors++; if (mw_ !== 1'b1) begin miscompares++; $display("FAIL rst_mw_: got %b want 1", mw_); end
    vectors++; if (data_oe !== 1'b0) begin miscompares++; $display("FAIL rst_data_oe: got %b want 0", data_oe); end
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL rst_ack: got %b want 0", ack); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (addr !== '0) begin miscompares++; $display("FAIL rst_addr: got %h want 0", addr); end
    vectors++; if (data_out !== '0) begin miscompares++; $display("FAIL rst_data_out: got %h want 0", data_out); end
    vectors++; if (rdata !== '0) begin miscompares++; $display("FAIL rst_rdata: got %h want 0", rdata); end
`ifdef SRAM_MASTER_READBACK_EN
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b want 0", err); end
`endif
    req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_write();
    int lat, slo, mrl, mwl, oel, bl; logic [M-1:0] rd; logic er; bit st, rel;
    run_txn(1'b1, N'(3), M'(4'hA), 0, lat, slo, mrl, mwl, oel, bl, rd, er, st, rel);
    ref_mem[3] = M'(4'hA);
    vectors++; if (lat !== WR_LAT) begin miscompares++; $display("FAIL wr_latency: got %0d want %0d", lat, WR_LAT); end
    vectors++; if (slo !== WR_LAT) begin miscompares++; $display("FAIL wr_s_low: got %0d want %0d", slo, WR_LAT); end
    vectors++; if (mwl !== W) begin miscompares++; $display("FAIL wr_mw_low: got %0d want %0d", mwl, W); end
    vectors++; if (mrl !== WR_MR) begin miscompares++; $display("FAIL wr_mr_low: got %0d want %0d", mrl, WR_MR); end
    vectors++; if (oel !== 2 + W) begin miscompares++; $display("FAIL wr_oe: got %0d want %0d", oel, 2 + W); end
    vectors++; if (rel !== 1'b1) begin miscompares++; $display("FAIL wr_release: got %b want 1", rel); end
  endtask

  task automatic test_read();
    int lat, slo, mrl, mwl, oel, bl; logic [M-1:0] rd; logic er; bit st, rel;
    run_txn(1'b0, N'(3), M'(0), 0, lat, slo, mrl, mwl, oel, bl, rd, er, st, rel);
    vectors++; if (rd !== ref_mem[3]) begin miscompares++; $display("FAIL rd_data: got %h want %h", rd, ref_mem[3]); end
    vectors++; if (lat !== RD_LAT) begin miscompares++; $display("FAIL rd_latency: got %0d want %0d", lat, RD_LAT); end
    vectors++; if (mwl !== 0) begin miscompares++; $display("FAIL rd_mw_low: got %0d want 0", mwl); end
    vectors++; if (mrl !== W) begin miscompares++; $display("FAIL rd_mr_low: got %0d want %0d", mrl, W); end
    vectors++; if (oel !== 0) begin miscompares++; $display("FAIL rd_oe: got %0d want 0", oel); end
  endtask

  task automatic test_handshake();
    int lat, slo, mrl, mwl, oel, bl; logic [M-1:0] rd; logic er; bit st, rel;
    run_txn(1'b0, N'(3), M'(0), 3, lat, slo, mrl, mwl, oel, bl, rd, er, st, rel);
    vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL hs_ack_held: got %b want 1", st); end
    vectors++; if (rel !== 1'b1) begin miscompares++; $display("FAIL hs_release: got %b want 1", rel); end
    vectors++; if (rd !== ref_mem[3]) begin miscompares++; $display("FAIL hs_data: got %h want %h", rd, ref_mem[3]); end
  endtask

  task automatic test_reset_mid_write();
    int lat, slo, mrl, mwl, oel, bl; logic [M-1:0] rd; logic er; bit st, rel;
    logic [M-1:0] oldv, newv;
    oldv = ref_mem[3];
    newv = oldv ^ M'(4'hF);
    @(negedge clock);
    req = 1'b1; we = 1'b1; addr_in = N'(3); wdata = newv;
    @(posedge clock); #1;
    @(posedge clock); #1;
    vectors++; if (mw_ !== 1'b0) begin miscompares++; $display("FAIL rmw_in_access: got mw_=%b want 0", mw_); end
    #2;
    reset = 1'b1;
    #1;
    vectors++; if ({s_, mr_, mw_} !== 3'b111) begin miscompares++; $display("FAIL rmw_strobes: got %b want 111", {s_, mr_, mw_}); end
    vectors++; if (data_oe !== 1'b0) begin miscompares++; $display("FAIL rmw_data_oe: got %b want 0", data_oe); end
    @(negedge clock);
    req = 1'b0; reset = 1'b0;
    @(posedge clock); #1;
    vectors++; if ({busy, s_} !== 2'b01) begin miscompares++; $display("FAIL rmw_idle: got busy,s_=%b want 01", {busy, s_}); end
    run_txn(1'b0, N'(3), M'(0), 0, lat, slo, mrl, mwl, oel, bl, rd, er, st, rel);
    vectors++; if (lat !== RD_LAT) begin miscompares++; $display("FAIL rmw_rd_latency: got %0d want %0d", lat, RD_LAT); end
    vectors++; if (rd !== oldv && rd !== newv) begin miscompares++; $display("FAIL rmw_rd_data: got %h want %h or %h", rd, oldv, newv); end
    run_txn(1'b1, N'(3), newv, 0, lat, slo, mrl, mwl, oel, bl, rd, er, st, rel);
    ref_mem[3] = newv;
  endtask

  task automatic test_random();
    int lat, slo, mrl, mwl, oel, bl, h, exp_lat; logic [M-1:0] rd, d; logic [N-1:0] a;
    logic er; bit st, rel, w;
    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom); a = N'($urandom); d = M'($urandom); h = $urandom_range(0, 2);
      run_txn(w, a, d, h, lat, slo, mrl, mwl, oel, bl, rd, er, st, rel);
      exp_lat = w ? WR_LAT : RD_LAT;
      vectors++; if (lat !== exp_lat) begin miscompares++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, exp_lat); end
      vectors++; if (slo !== exp_lat) begin miscompares++; $display("FAIL rnd%0d_s_low: got %0d want %0d", i, slo, exp_lat); end
      vectors++; if (mrl !== (w ? WR_MR : W)) begin miscompares++; $display("FAIL rnd%0d_mr_low: got %0d want %0d", i, mrl, w ? WR_MR : W); end
      vectors++; if (mwl !== (w ? W : 0)) begin miscompares++; $display("FAIL rnd%0d_mw_low: got %0d want %0d", i, mwl, w ? W : 0); end
      vectors++; if (oel !== (w ? 2 + W : 0)) begin miscompares++; $display("FAIL rnd%0d_oe: got %0d want %0d", i, oel, w ? 2 + W : 0); end
      vectors++; if (bl !== 0) begin miscompares++; $display("FAIL rnd%0d_overlap: got %0d want 0", i, bl); end
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_err: got %b want 0", i, er); end
      vectors++; if (st !== 1'b1 || rel !== 1'b1) begin miscompares++; $display("FAIL rnd%0d_handshake: got held=%b rel=%b want 1 1", i, st, rel); end
      if (!w) begin
        vectors++; if (rd !== ref_mem[a]) begin miscompares++; $display("FAIL rnd%0d_rdata: got %h want %h", i, rd, ref_mem[a]); end
      end else begin
        ref_mem[a] = d;
      end
    end
  endtask

`ifdef SRAM_MASTER_READBACK_EN
  task automatic test_readback();
    int lat, slo, mrl, mwl, oel, bl; logic [M-1:0] rd; logic er; bit st, rel;
    stuck0 = 1'b0;
    run_txn(1'b1, N'(5), M'(4'h5), 0, lat, slo, mrl, mwl, oel, bl, rd, er, st, rel);
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL rb_clean_err: got %b want 0", er); end
    vectors++; if (lat !== 4 + 2 * W) begin miscompares++; $display("FAIL rb_latency: got %0d want %0d", lat, 4 + 2 * W); end
    stuck0 = 1'b1;
    run_txn(1'b1, N'(5), M'(4'h5), 0, lat, slo, mrl, mwl, oel, bl, rd, er, st, rel);
    vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL rb_stuck_err: got %b want 1", er); end
    stuck0 = 1'b0;
    run_txn(1'b0, N'(5), M'(0), 0, lat, slo, mrl, mwl, oel, bl, rd, er, st, rel);
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL rb_read_clears: got %b want 0", er); end
    vectors++; if (rd !== M'(4'h4)) begin miscompares++; $display("FAIL rb_stuck_data: got %h want 4", rd); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2**N; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    reset = 1'b1; req = 1'b0; we = 1'b0; addr_in = '0; wdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_handshake();
    test_reset_mid_write();
    test_random();
`ifdef SRAM_MASTER_READBACK_EN
    test_readback();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
